// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel receiver: start bit (1), WIDTH data bits LSB-first,
// optional even-parity bit, stop bit (0). One-cycle valid / frame-error pulses.
module serial_word_deserializer #(
   parameter int WIDTH     = 8,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             parity_err,
   output logic             frame_err,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic               par_q, par_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               valid_q, valid_d;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               busy_q, busy_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      dout_d  = dout_q;
      // Pulses self-clear every clock, independent of the strobe
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;

      if (din_en) begin
         case (state_q)
            S_IDLE: begin
               if (din) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               shift_d = {din, shift_q[WIDTH-1:1]};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               par_d   = din;
               state_d = S_STOP;
            end
            S_STOP: begin
               if (!din) begin
                  dout_d  = shift_q;
                  valid_d = 1'b1;
                  perr_d  = (PARITY_EN != 0) && (par_q != (^shift_q));
               end else begin
                  ferr_d  = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench: one parity-enabled receiver (u_dut) and one without parity (u_dut_np).
module tb_serial_word_deserializer;

   logic       clk;
   logic       reset;
   logic       din;
   logic       din_np;
   logic       din_en;
   logic [7:0] dout;
   logic       dout_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
   logic [7:0] dout_np;
   logic       dout_valid_np;
   logic       parity_err_np;
   logic       frame_err_np;
   logic       busy_np;

   int n_vec = 0;
   int n_err = 0;

   // Free-running observation counters, sampled on the falling edge
   int cyc       = 0;
   int busy_cnt  = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   int v_cyc[$];
   int v_cyc_np[$];

   serial_word_deserializer #(.WIDTH(8), .PARITY_EN(1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_en     (din_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   serial_word_deserializer #(.WIDTH(8), .PARITY_EN(0)) u_dut_np (
      .clk        (clk),
      .reset      (reset),
      .din        (din_np),
      .din_en     (din_en),
      .dout       (dout_np),
      .dout_valid (dout_valid_np),
      .parity_err (parity_err_np),
      .frame_err  (frame_err_np),
      .busy       (busy_np)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (dout_valid) begin
         valid_cnt = valid_cnt + 1;
         v_cyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (dout_valid_np) v_cyc_np.push_back(cyc);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // One strobed bit; gap-1 non-strobe cycles with random din precede it
   task automatic send_bit(input bit sel, input logic b, input int gap);
      for (int k = 1; k < gap; k++) begin
         din    = 1'($urandom_range(0, 1));
         din_np = 1'($urandom_range(0, 1));
         din_en = 1'b0;
         @(posedge clk); #1;
      end
      din    = sel ? 1'b0 : b;
      din_np = sel ? b : 1'b0;
      din_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                             input logic stp, input int gap);
      send_bit(sel, 1'b1, gap);
      for (int i = 0; i < 8; i++) send_bit(sel, d[i], gap);
      if (!sel) send_bit(sel, par, gap);
      send_bit(sel, stp, gap);
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) begin
         din    = 1'b0;
         din_np = 1'b0;
         din_en = en;
         @(posedge clk); #1;
      end
   endtask

   int b0, v0, f0, q0, q1;

   initial begin
      reset  = 1'b0;
      din    = 1'b0;
      din_np = 1'b0;
      din_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_dout",      32'(dout),       32'h0);
      check_val("rst_valid",     32'(dout_valid), 32'h0);
      check_val("rst_perr",      32'(parity_err), 32'h0);
      check_val("rst_ferr",      32'(frame_err),  32'h0);
      check_val("rst_busy",      32'(busy),       32'h0);
      check_val("rst_np_busy",   32'(busy_np),    32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      idle(2, 1'b1);

      // Good frame 0xA5, even parity 0
      b0 = busy_cnt; v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1);
      check_val("good_valid", 32'(dout_valid), 32'h1);
      check_val("good_dout",  32'(dout),       32'hA5);
      check_val("good_perr",  32'(parity_err), 32'h0);
      check_val("good_ferr",  32'(frame_err),  32'h0);
      check_val("good_busy_low", 32'(busy),    32'h0);
      idle(3, 1'b1);
      check_val("good_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      check_val("good_busy_cycles",  32'(busy_cnt - b0),  32'd10);
      check_val("good_ferr_pulses",  32'(ferr_cnt - f0),  32'd0);

      // Frame error: 0x3C, correct parity, bad stop; dout must stay 0xA5
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1);
      check_val("ferr_flag",  32'(frame_err),  32'h1);
      check_val("ferr_valid", 32'(dout_valid), 32'h0);
      check_val("ferr_dout",  32'(dout),       32'hA5);
      idle(2, 1'b1);
      check_val("ferr_pulses",  32'(ferr_cnt - f0),  32'd1);
      check_val("ferr_nvalid",  32'(valid_cnt - v0), 32'd0);

      // Parity error: 0x3C has even parity 0, send 1
      send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1);
      check_val("perr_valid", 32'(dout_valid), 32'h1);
      check_val("perr_dout",  32'(dout),       32'h3C);
      check_val("perr_flag",  32'(parity_err), 32'h1);
      idle(1, 1'b1);
      check_val("perr_clear", 32'(parity_err), 32'h0);

      // Strobe every 4th cycle, random din between strobes
      b0 = busy_cnt; v0 = valid_cnt;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 4);
      check_val("gap_valid", 32'(dout_valid), 32'h1);
      check_val("gap_dout",  32'(dout),       32'hA5);
      check_val("gap_perr",  32'(parity_err), 32'h0);
      idle(3, 1'b0);
      check_val("gap_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      check_val("gap_busy_cycles",  32'(busy_cnt - b0),  32'd40);
      idle(1, 1'b1);

      // Reset after start + 4 data bits of 0xA5
      send_bit(1'b0, 1'b1, 1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'(8'hA5 >> i), 1);
      check_val("mid_busy_before", 32'(busy), 32'h1);
      #2 reset = 1'b0;
      #1;
      check_val("mid_rst_dout",  32'(dout),       32'h0);
      check_val("mid_rst_busy",  32'(busy),       32'h0);
      check_val("mid_rst_valid", 32'(dout_valid), 32'h0);
      din = 1'b0; din_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("mid_idle_busy", 32'(busy), 32'h0);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1);
      check_val("post_rst_valid", 32'(dout_valid), 32'h1);
      check_val("post_rst_dout",  32'(dout),       32'h5A);
      check_val("post_rst_perr",  32'(parity_err), 32'h0);
      idle(2, 1'b1);

      // Back-to-back 0x01 (parity 1) then 0xFF (parity 0)
      f0 = ferr_cnt;
      send_frame(1'b0, 8'h01, 1'b1, 1'b0, 1);
      check_val("b2b_first_dout", 32'(dout),       32'h01);
      check_val("b2b_first_perr", 32'(parity_err), 32'h0);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1);
      check_val("b2b_second_valid", 32'(dout_valid), 32'h1);
      check_val("b2b_second_dout",  32'(dout),       32'hFF);
      check_val("b2b_second_perr",  32'(parity_err), 32'h0);
      idle(2, 1'b1);
      check_val("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
      if (v_cyc.size() >= 2) begin
         q0 = v_cyc[v_cyc.size()-2];
         q1 = v_cyc[v_cyc.size()-1];
         check_val("b2b_spacing", 32'(q1 - q0), 32'd11);
      end else begin
         check_val("b2b_pulse_count", 32'(v_cyc.size()), 32'd2);
      end

      // Same pair without parity bit
      send_frame(1'b1, 8'h01, 1'b0, 1'b0, 1);
      check_val("np_first_dout", 32'(dout_np), 32'h01);
      send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1);
      check_val("np_second_valid", 32'(dout_valid_np), 32'h1);
      check_val("np_second_dout",  32'(dout_np),       32'hFF);
      check_val("np_second_perr",  32'(parity_err_np), 32'h0);
      idle(2, 1'b1);
      if (v_cyc_np.size() >= 2) begin
         q0 = v_cyc_np[v_cyc_np.size()-2];
         q1 = v_cyc_np[v_cyc_np.size()-1];
         check_val("np_spacing", 32'(q1 - q0), 32'd10);
      end else begin
         check_val("np_pulse_count", 32'(v_cyc_np.size()), 32'd2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
